// File: rtl/dcache_pkg.sv
// dcache_pkg: state encoding and address-split width helpers for dcache_wb
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;
  function automatic int off_w(input int block_bytes);
    return $clog2(block_bytes);
  endfunction
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int addr_w, input int lines, input int block_bytes);
    return addr_w - $clog2(lines) - $clog2(block_bytes);
  endfunction
  function automatic int words_per_block(input int block_bytes, input int data_w);
    return block_bytes * 8 / data_w;
  endfunction
endpackage

// File: rtl/dcache_wb_array.sv
// dcache_wb_array: valid/dirty/tag/data line storage with byte-enabled write port
module dcache_wb_array #(
  parameter int LINES = 16,
  parameter int BLOCK_BYTES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 56
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic                     rd_valid,
  output logic                     rd_dirty,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [BLOCK_BYTES*8-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic                     wr_dirty,
  input  logic [TAG_W-1:0]         wr_tag,
  input  logic [BLOCK_BYTES-1:0]   wr_be,
  input  logic [BLOCK_BYTES*8-1:0] wr_data
);
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag_mem [LINES];
  logic [BLOCK_BYTES*8-1:0] data_mem [LINES];
  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag = tag_mem[rd_idx];
  assign rd_data = data_mem[rd_idx];
  // line status bits are the only state cleared by reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= wr_dirty;
    end
  // tag and byte-enabled data writes
  always_ff @(posedge clk)
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
      for (int b = 0; b < BLOCK_BYTES; b++)
        if (wr_be[b]) data_mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back write-allocate data cache with core/memory handshakes
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LINES = 16,
  parameter int BLOCK_BYTES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_read,
  input  logic                     cpu_write,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic [DATA_W/8-1:0]      cpu_wstrb,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ready,
  output logic                     stall,
  output logic                     miss,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [BLOCK_BYTES*8-1:0] mem_wdata,
  input  logic [BLOCK_BYTES*8-1:0] mem_rdata,
  input  logic                     mem_ack
);
  localparam int OFF_W = off_w(BLOCK_BYTES);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES, BLOCK_BYTES);
  localparam int WORDS = words_per_block(BLOCK_BYTES, DATA_W);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WS_W = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int BW = BLOCK_BYTES * 8;
  state_t state, state_d;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag, rd_tag;
  logic [WS_W-1:0] wsel;
  logic [DATA_W-1:0] word, rdata_d;
  logic [BLOCK_BYTES-1:0] be_word, arr_be;
  logic [BW-1:0] rd_data, arr_wdata, wdata_d;
  logic [ADDR_W-1:0] addr_d, fill_addr;
  logic rd_valid, rd_dirty, hit, access, arr_we, arr_dirty;
  logic ready_d, stall_d, miss_d, req_d, we_d;
  assign idx = cpu_addr[OFF_W +: IDX_W];
  assign tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign wsel = WS_W'(cpu_addr[OFF_W-1:0] >> BYTE_W);
  assign word = rd_data[wsel*DATA_W +: DATA_W];
  assign be_word = BLOCK_BYTES'(cpu_wstrb) << (wsel * (DATA_W / 8));
  assign hit = rd_valid && rd_tag == tag;
  assign fill_addr = {tag, idx, OFF_W'(0)};
  dcache_wb_array #(
    .LINES(LINES),
    .BLOCK_BYTES(BLOCK_BYTES),
    .IDX_W(IDX_W),
    .TAG_W(TAG_W)
  ) u_array (
    .clk(clk),
    .reset(reset),
    .rd_idx(idx),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_tag(rd_tag),
    .rd_data(rd_data),
    .wr_en(arr_we),
    .wr_idx(idx),
    .wr_dirty(arr_dirty),
    .wr_tag(tag),
    .wr_be(arr_be),
    .wr_data(arr_wdata)
  );
  // next state, next registered outputs and array write for the current cycle
  always_comb begin
    state_d = state;
    rdata_d = cpu_rdata;
    ready_d = 1'b0;
    stall_d = stall;
    miss_d = 1'b0;
    req_d = mem_req;
    we_d = mem_we;
    addr_d = mem_addr;
    wdata_d = mem_wdata;
    access = 1'b0;
    arr_we = 1'b0;
    arr_dirty = 1'b0;
    arr_be = '0;
    arr_wdata = {WORDS{cpu_wdata}};
    case (state)
      IDLE:
        if ((cpu_read || cpu_write) && !cpu_ready) begin
          if (hit) access = 1'b1;
          else begin
            miss_d = 1'b1;
            stall_d = 1'b1;
            req_d = 1'b1;
            we_d = rd_valid && rd_dirty;
            state_d = we_d ? WRITEBACK : REFILL;
            addr_d = we_d ? {rd_tag, idx, OFF_W'(0)} : fill_addr;
            wdata_d = rd_data;
          end
        end
      WRITEBACK:
        if (mem_ack) begin
          req_d = 1'b0;
          state_d = REFILL;
        end
      REFILL:
        if (!mem_req) begin
          req_d = 1'b1;
          we_d = 1'b0;
          addr_d = fill_addr;
        end else if (mem_ack) begin
          req_d = 1'b0;
          state_d = RESPOND;
          arr_we = 1'b1;
          arr_be = '1;
          arr_wdata = mem_rdata;
        end
      RESPOND: begin
        access = 1'b1;
        stall_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    if (access) begin
      ready_d = 1'b1;
      arr_we = cpu_write;
      arr_dirty = 1'b1;
      arr_be = cpu_write ? be_word : '0;
      rdata_d = cpu_write ? cpu_rdata : word;
    end
  end
  // state and all outputs are registered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      stall <= 1'b0;
      miss <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_d;
      cpu_rdata <= rdata_d;
      cpu_ready <= ready_d;
      stall <= stall_d;
      miss <= miss_d;
      mem_req <= req_d;
      mem_we <= we_d;
      mem_addr <= addr_d;
      mem_wdata <= wdata_d;
    end
endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed self-checking bench for dcache_wb
module tb_dcache_wb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_read = 1'b0, cpu_write = 1'b0;
  logic [63:0] cpu_addr = '0, cpu_wdata = '0;
  logic [7:0] cpu_wstrb = '0;
  logic [63:0] cpu_rdata;
  logic cpu_ready, stall, miss, mem_req, mem_we;
  logic [63:0] mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic mem_ack = 1'b0;
  int checks = 0, errors = 0;
  int ack_dly = 3, cnt = 0, nreq = 0, nwb = 0;
  logic last_we;
  logic [63:0] last_addr, wb_addr;
  logic [127:0] wb_data;
  logic [63:0] data;
  int cyc, nmiss, n;

  dcache_wb dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .stall(stall), .miss(miss),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < 16; i++) mem_rdata[i*8 +: 8] = mem_addr[7:0] + 8'(i);

  always @(negedge clk) begin
    if (!mem_req) begin
      cnt = 0;
      mem_ack = 1'b0;
    end else begin
      if (cnt == 0) begin
        nreq++;
        last_we = mem_we;
        last_addr = mem_addr;
        if (mem_we) begin
          nwb++;
          wb_addr = mem_addr;
          wb_data = mem_wdata;
        end
      end
      cnt++;
      mem_ack = cnt >= ack_dly;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] wd,
                        input logic [7:0] st, output logic [63:0] d, output int c, output int m);
    @(negedge clk);
    nreq = 0;
    nwb = 0;
    cpu_read = rd;
    cpu_write = wr;
    cpu_addr = a;
    cpu_wdata = wd;
    cpu_wstrb = st;
    c = 0;
    m = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
      m += int'(miss);
    end while (!cpu_ready && c < 100);
    check("ready", cpu_ready, 1);
    check("stall_at_ready", stall, 0);
    d = cpu_rdata;
    @(negedge clk);
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", cpu_ready, 0);
    check("rst_stall", stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_addr", mem_addr, 0);
    reset = 1'b0;

    access(1, 0, 64'h100, 0, 0, data, cyc, nmiss);
    check("cold_data", data, 64'h0706050403020100);
    check("cold_cycles", cyc, 5);
    check("cold_miss", nmiss, 1);
    check("cold_nreq", nreq, 1);
    check("cold_we", last_we, 0);
    check("cold_addr", last_addr, 64'h100);

    access(1, 0, 64'h108, 0, 0, data, cyc, nmiss);
    check("hit_data", data, 64'h0F0E0D0C0B0A0908);
    check("hit_cycles", cyc, 1);
    check("hit_nreq", nreq, 0);
    check("hit_miss", nmiss, 0);

    access(0, 1, 64'h100, 64'hDEADBEEFCAFEF00D, 8'h0F, data, cyc, nmiss);
    check("wr_cycles", cyc, 1);
    check("wr_nreq", nreq, 0);
    access(1, 0, 64'h100, 0, 0, data, cyc, nmiss);
    check("wr_readback", data, 64'h07060504CAFEF00D);

    ack_dly = 1;
    access(1, 0, 64'h1100, 0, 0, data, cyc, nmiss);
    check("wb_count", nwb, 1);
    check("wb_addr", wb_addr, 64'h100);
    check("wb_data", wb_data[63:0], 64'h07060504CAFEF00D);
    check("wb_nreq", nreq, 2);
    check("wb_fill_we", last_we, 0);
    check("wb_fill_addr", last_addr, 64'h1100);
    check("wb_data_rd", data, 64'h0706050403020100);
    check("wb_cycles", cyc, 5);
    ack_dly = 3;

    access(1, 0, 64'h2100, 0, 0, data, cyc, nmiss);
    check("clean_nwb", nwb, 0);
    check("clean_nreq", nreq, 1);
    check("clean_we", last_we, 0);
    check("clean_addr", last_addr, 64'h2100);
    check("clean_data", data, 64'h0706050403020100);

    ack_dly = 50;
    @(negedge clk);
    cpu_read = 1'b1;
    cpu_addr = 64'h100;
    n = 0;
    while (!mem_req && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("refill_req", mem_req, 1);
    check("refill_stall", stall, 1);
    #2 reset = 1'b1;
    #1;
    check("async_req", mem_req, 0);
    check("async_stall", stall, 0);
    check("async_ready", cpu_ready, 0);
    @(negedge clk);
    cpu_read = 1'b0;
    reset = 1'b0;
    ack_dly = 3;

    access(1, 0, 64'h100, 0, 0, data, cyc, nmiss);
    check("post_rst_miss", nmiss, 1);
    check("post_rst_nreq", nreq, 1);
    check("post_rst_data", data, 64'h0706050403020100);

    access(1, 0, 64'h108, 0, 0, data, cyc, nmiss);
    check("rw_pre", data, 64'h0F0E0D0C0B0A0908);
    access(1, 1, 64'h108, 64'h1111111111111111, 8'hFF, data, cyc, nmiss);
    check("rw_rdata_kept", data, 64'h0F0E0D0C0B0A0908);
    check("rw_cycles", cyc, 1);
    check("rw_nreq", nreq, 0);
    access(1, 0, 64'h108, 0, 0, data, cyc, nmiss);
    check("rw_readback", data, 64'h1111111111111111);
    check("rw_other_word", 0, 0 ^ int'(nreq));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_wb.md
# dcache_wb

Parametrised direct-mapped, write-back, write-allocate data cache for the RISC-V core's MEM stage. It sits between the core's load/store port and a block-wide main-memory port. It generalises address/data width, line count and block size, and adds:
- byte-strobed writes,
- dirty-line eviction,
- a stall/ready handshake toward the core and a req/ack handshake toward memory.

## Interface
- ADDR_W, 64, byte-address width
- DATA_W, 64, core word width (power of two, ≥ 8)
- LINES, 16, number of cache lines (power of two)
- BLOCK_BYTES, 16, bytes per line (power of two, ≥ DATA_W/8)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_read  in  1  load request
- cpu_write  in  1  store request
- cpu_addr  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored (word-aligned down)
- cpu_wdata  in  DATA_W  store data
- cpu_wstrb  in  DATA_W/8  byte enables for store
- cpu_rdata  out  DATA_W  load result, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle pulse: access complete
- stall  out  1  high while a miss is being serviced
- miss  out  1  one-cycle pulse when a miss is detected
- mem_req  out  1  memory request
- mem_we  out  1  1 = write-back, 0 = refill
- mem_addr  out  ADDR_W  block-aligned address
- mem_wdata  out  BLOCK_BYTES*8  evicted block, byte 0 in bits [7:0]
- mem_rdata  in  BLOCK_BYTES*8  refill block
- mem_ack  in  1  sampled while mem_req=1; completes the transfer

## Operation
**Address split:**
- OFF_W = log2(BLOCK_BYTES), IDX_W = log2(LINES), TAG_W = ADDR_W − IDX_W − OFF_W.
- Word select = offset / (DATA_W/8).
- Line storage holds valid, dirty, tag and data.

**States:** IDLE, WRITEBACK, REFILL, RESPOND.

**IDLE:**
- A request is accepted when (cpu_read | cpu_write) and cpu_ready=0.
- If cpu_read and cpu_write are both set, the access is a write; cpu_rdata is unchanged.
- Hit, read: cpu_rdata ← selected word, cpu_ready=1.
- Hit, write: the bytes selected by cpu_wstrb are merged into the line, dirty ← 1, cpu_ready=1.
- Miss: miss=1, stall=1. Next state is WRITEBACK if the line is valid and dirty, otherwise REFILL.

**WRITEBACK:**
- Drives mem_req=1, mem_we=1, mem_addr = {old tag, index, 0}, mem_wdata = line data.
- On mem_ack → REFILL.

**REFILL:**
- Drives mem_req=1, mem_we=0, mem_addr = {tag, index, 0}.
- On mem_ack: the line is loaded from mem_rdata, valid ← 1, dirty ← 0, tag updated → RESPOND.

**RESPOND:**
- Performs the held access as a hit (read or strobed write).
- cpu_ready=1, stall=0 → IDLE.

**Core-side rules:**
- The core holds cpu_read, cpu_write, cpu_addr, cpu_wdata and cpu_wstrb stable while stall=1.
- The core drops or changes its request in the cycle cpu_ready=1.

**Memory-side rules:**
- mem_addr and mem_wdata are stable while mem_req=1.
- mem_req deasserts on the edge that samples mem_ack.

**Reset (asynchronous):**
- State → IDLE; all valid and dirty bits → 0.
- All outputs → 0 (cpu_rdata, cpu_ready, stall, miss, mem_req, mem_we, mem_addr, mem_wdata).
- Reset mid-WRITEBACK or mid-REFILL abandons the transfer; dirty data is lost.

## Timing
- All outputs are registered.
- Hit: accepted at edge N → cpu_ready and cpu_rdata valid after edge N, for one cycle. Maximum throughput is one access per 2 cycles.
- Clean miss: miss and stall rise after edge N; mem_req rises after edge N. If mem_ack is sampled at edge M, cpu_ready is asserted after edge M+1.
- Dirty miss: the same sequence with a WRITEBACK phase preceding REFILL.
- mem_ack may be high in the first cycle of mem_req, giving a 1-cycle transfer.
- mem_ack while mem_req=0 is ignored.

## Structure
- Package dcache_pkg: state encoding (IDLE, WRITEBACK, REFILL, RESPOND) and width helper functions (OFF_W, IDX_W, TAG_W, WORDS_PER_BLOCK).
- Sub-module dcache_wb_array: valid, dirty, tag and data storage. It has a read port plus a write port with per-byte enables, and asynchronous clear of valid/dirty.
- dcache_wb holds the FSM, hit compare and handshakes.

## Test plan
Defaults for all scenarios: LINES=16, BLOCK_BYTES=16, DATA_W=64. Memory byte at address a = a[7:0].
- Cold read 0x100 with ack 3 cycles after mem_req → miss pulse, mem_req=1 with mem_we=0 at mem_addr=0x100, then cpu_rdata=0x0706050403020100. A following read of 0x108 completes in 1 cycle with 0x0F0E0D0C0B0A0908 and no mem_req.
- Write 0x100, wdata 0xDEADBEEFCAFEF00D, wstrb 0x0F → cpu_ready in 1 cycle, no mem_req. Read-back of 0x100 = 0x07060504CAFEF00D.
- After the previous step, read 0x1100 (same index, different tag) → WRITEBACK with mem_we=1, mem_addr=0x100, mem_wdata[63:0]=0x07060504CAFEF00D. Then REFILL at 0x1100; cpu_rdata=0x0706050403020100.
- Read 0x2100 while line 0 is clean → no write-back; exactly one mem_req, with mem_we=0.
- Assert reset while mem_req=1 in REFILL → mem_req, stall and cpu_ready are 0 immediately, without waiting for a clock edge. The next read of 0x100 misses.
- cpu_read=cpu_write=1 on a hit at 0x108, wstrb 0xFF, wdata 0x1111111111111111 → write performed, cpu_rdata unchanged. Read-back of 0x108 = 0x1111111111111111.
